// File: rtl/atm_ledger_if.sv
// atm_ledger_if: terminal request/response and ledger memory bus shared by the
// ledger arbiter (master modport) and the terminals plus ledger RAM (slave modport).
interface atm_ledger_if #(
  parameter int NUM_REQ = 4,
  parameter int BAL_W   = 12,
  parameter int IDX_W   = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [IDX_W*NUM_REQ-1:0] req_src;
  logic [IDX_W*NUM_REQ-1:0] req_dst;
  logic [BAL_W*NUM_REQ-1:0] req_amt;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     rsp_valid;
  logic [1:0]               rsp_status;
  logic [BAL_W-1:0]         rsp_balance;
  logic [IDX_W-1:0]         mem_addr;
  logic                     mem_rd;
  logic                     mem_wr;
  logic [BAL_W-1:0]         mem_wdata;
  logic [BAL_W-1:0]         mem_rdata;
  logic [15:0]              txn_count;

  modport master (
    input  req, req_op, req_src, req_dst, req_amt, mem_rdata,
    output grant, busy, rsp_valid, rsp_status, rsp_balance,
           mem_addr, mem_rd, mem_wr, mem_wdata, txn_count
  );

  modport slave (
    output req, req_op, req_src, req_dst, req_amt, mem_rdata,
    input  grant, busy, rsp_valid, rsp_status, rsp_balance,
           mem_addr, mem_rd, mem_wr, mem_wdata, txn_count
  );
endinterface

// File: rtl/atm_ledger_arbiter.sv
// atm_ledger_arbiter: round-robin arbiter that serialises ATM terminal requests
// onto one single-port ledger RAM and runs an all-or-nothing read-check-write
// sequence (balance, deposit, withdraw, transfer) per grant.
// Optional feature: define ATM_LEDGER_TXN_COUNT_EN to build the committed-
// transaction counter; otherwise txn_count is tied to zero.
module atm_ledger_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BAL_W   = 12,
  parameter int IDX_W   = 2
) (
  input logic          clk,
  input logic          rst,
  atm_ledger_if.master bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] OP_BAL = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_WDR = 2'b10;
  localparam logic [1:0] OP_XFR = 2'b11;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_NSF    = 2'b01;
  localparam logic [1:0] ST_OVF    = 2'b10;
  localparam logic [1:0] ST_BADDST = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RD_SRC, CHK_SRC, RD_DST, CHK_DST, WR_SRC, WR_DST, RESP
  } state_t;

  // Unsigned add with the carry kept in the top bit for overflow detection.
  function automatic logic [BAL_W:0] add_carry(input logic [BAL_W-1:0] a,
                                               input logic [BAL_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  state_t             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [1:0]         op_q;
  logic [IDX_W-1:0]   src_q, dst_q;
  logic [BAL_W-1:0]   amt_q, bal_q, dnew_q;
  logic               busy_q, rsp_valid_q, mem_rd_q, mem_wr_q;
  logic [1:0]         rsp_status_q;
  logic [BAL_W-1:0]   rsp_balance_q, mem_wdata_q;
  logic [IDX_W-1:0]   mem_addr_q;

  logic               found_d;
  logic [PTR_W-1:0]   win_d, cand_d;
  logic [NUM_REQ-1:0] win_oh_d;
  logic [1:0]         win_op_d;
  logic [IDX_W-1:0]   win_src_d, win_dst_d;
  logic [BAL_W-1:0]   win_amt_d;
  logic [BAL_W:0]     sum_d;

  assign sum_d = add_carry(bus.mem_rdata, amt_q);

  // Round-robin winner search starting at the priority pointer, plus its fields.
  always_comb begin
    found_d   = 1'b0;
    win_d     = '0;
    cand_d    = '0;
    win_oh_d  = '0;
    win_op_d  = '0;
    win_src_d = '0;
    win_dst_d = '0;
    win_amt_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_d = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found_d && bus.req[cand_d]) begin
        found_d = 1'b1;
        win_d   = cand_d;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found_d && (win_d == PTR_W'(i))) begin
        win_oh_d[i] = 1'b1;
        win_op_d    = bus.req_op[2*i +: 2];
        win_src_d   = bus.req_src[IDX_W*i +: IDX_W];
        win_dst_d   = bus.req_dst[IDX_W*i +: IDX_W];
        win_amt_d   = bus.req_amt[BAL_W*i +: BAL_W];
      end
    end
  end

  // Transaction FSM; every output is registered on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= ST_OK;
      rsp_balance_q <= '0;
      mem_addr_q    <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q    <= win_oh_d;
            ptr_q      <= PTR_W'((int'(win_d) + 1) % NUM_REQ);
            op_q       <= win_op_d;
            src_q      <= win_src_d;
            dst_q      <= win_dst_d;
            amt_q      <= win_amt_d;
            busy_q     <= 1'b1;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= win_src_d;
            state_q    <= RD_SRC;
          end
        end
        RD_SRC: state_q <= CHK_SRC;
        CHK_SRC: begin
          bal_q         <= bus.mem_rdata;
          rsp_balance_q <= bus.mem_rdata;
          rsp_status_q  <= ST_OK;
          case (op_q)
            OP_BAL: begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
            OP_DEP: begin
              if (sum_d[BAL_W]) begin
                rsp_status_q <= ST_OVF;
                rsp_valid_q  <= 1'b1;
                state_q      <= RESP;
              end else begin
                mem_wr_q      <= 1'b1;
                mem_addr_q    <= src_q;
                mem_wdata_q   <= sum_d[BAL_W-1:0];
                rsp_balance_q <= sum_d[BAL_W-1:0];
                state_q       <= WR_SRC;
              end
            end
            OP_WDR: begin
              if (amt_q > bus.mem_rdata) begin
                rsp_status_q <= ST_NSF;
                rsp_valid_q  <= 1'b1;
                state_q      <= RESP;
              end else begin
                mem_wr_q      <= 1'b1;
                mem_addr_q    <= src_q;
                mem_wdata_q   <= bus.mem_rdata - amt_q;
                rsp_balance_q <= bus.mem_rdata - amt_q;
                state_q       <= WR_SRC;
              end
            end
            default: begin
              if (dst_q == src_q) begin
                rsp_status_q <= ST_BADDST;
                rsp_valid_q  <= 1'b1;
                state_q      <= RESP;
              end else if (amt_q > bus.mem_rdata) begin
                rsp_status_q <= ST_NSF;
                rsp_valid_q  <= 1'b1;
                state_q      <= RESP;
              end else begin
                mem_rd_q   <= 1'b1;
                mem_addr_q <= dst_q;
                state_q    <= RD_DST;
              end
            end
          endcase
        end
        RD_DST: state_q <= CHK_DST;
        CHK_DST: begin
          // Both writes are decided here so a destination overflow writes nothing.
          if (sum_d[BAL_W]) begin
            rsp_status_q <= ST_OVF;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            dnew_q        <= sum_d[BAL_W-1:0];
            mem_wr_q      <= 1'b1;
            mem_addr_q    <= src_q;
            mem_wdata_q   <= bal_q - amt_q;
            rsp_balance_q <= bal_q - amt_q;
            state_q       <= WR_SRC;
          end
        end
        WR_SRC: begin
          if (op_q == OP_XFR) begin
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= dst_q;
            mem_wdata_q <= dnew_q;
            state_q     <= WR_DST;
          end else begin
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        WR_DST: begin
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ATM_LEDGER_TXN_COUNT_EN
  logic [15:0] txn_q;

  // Count committed ledger-changing transactions; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_q <= '0;
    end else if ((state_q == RESP) && (rsp_status_q == ST_OK) && (op_q != OP_BAL)) begin
      txn_q <= txn_q + 16'd1;
    end
  end

  assign bus.txn_count = txn_q;
`else
  assign bus.txn_count = 16'd0;
`endif

  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_status  = rsp_status_q;
  assign bus.rsp_balance = rsp_balance_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_wdata   = mem_wdata_q;
endmodule
